// File: rtl/fetch_chan_resp_pkg.sv
// Shared frontend definitions for the fetch-request channel responder:
// FSM state encoding, line/beat geometry and the PC slice macro.
`ifndef FETCH_CHAN_RESP_DEFS
`define FETCH_CHAN_RESP_DEFS
// Bits of a fetch PC that select a 16-byte line (drops the in-line offset).
`define PC_RANGE(aw) (aw)-1:fetch_chan_resp_pkg::LINE_OFF_W
`endif

package fetch_chan_resp_pkg;

    localparam int LINE_BYTES = 16;
    localparam int BEAT_BYTES = 8;
    localparam int LINE_OFF_W = $clog2(LINE_BYTES);

    typedef enum logic [2:0] {
        FCR_IDLE  = 3'd0,
        FCR_REQ0  = 3'd1,
        FCR_WAIT0 = 3'd2,
        FCR_REQ1  = 3'd3,
        FCR_WAIT1 = 3'd4,
        FCR_DONE  = 3'd5,
        FCR_DRAIN = 3'd6
    } fcr_state_t;

    // True in the states where a memory read is outstanding.
    function automatic logic fcr_resp_expected(fcr_state_t s);
        return (s == FCR_WAIT0) || (s == FCR_WAIT1) || (s == FCR_DRAIN);
    endfunction

endpackage

// File: rtl/fetch_chan_resp.sv
// Fetch-request channel responder: accepts a PC, reads its 16-byte line as
// two 64-bit beats from memory and reports the line with a one-cycle pulse.
// A redirect discards in-flight work so a stale line is never reported.
module fetch_chan_resp
    import fetch_chan_resp_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int BEAT_W = 64
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  redirect_valid,
    input  logic                  pc_index_valid,
    input  logic [ADDR_W-1:0]     pc_index,
    output logic                  pc_index_ready,
    output logic                  pc_operation_done,
    output logic [2*BEAT_W-1:0]   fetch_line,
    output logic [ADDR_W-1:0]     fetch_line_pc,
    output logic                  mem_req_valid,
    output logic [ADDR_W-1:0]     mem_req_addr,
    input  logic                  mem_req_ready,
    input  logic                  mem_resp_valid,
    input  logic [BEAT_W-1:0]     mem_resp_data
);

    fcr_state_t                state_reg, state_next;
    logic [ADDR_W-1:0]         base_reg;
    logic [2*BEAT_W-1:0]       line_out_reg;
    logic [ADDR_W-1:0]         line_pc_reg;
    logic [2*BEAT_W-1:0]       line_buf;
    logic                      accept;

    // The in-line offset of the PC is irrelevant: lines are always aligned.
    logic unused_pc_offset;
    assign unused_pc_offset = &{1'b0, pc_index[LINE_OFF_W-1:0]};

    // Outputs are forced inactive while reset is held so the reset cycle
    // itself already shows reset values.
    assign pc_index_ready    = reset_n && (state_reg == FCR_IDLE) && !redirect_valid;
    assign pc_operation_done = reset_n && (state_reg == FCR_DONE) && !redirect_valid;
    assign mem_req_valid     = reset_n && ((state_reg == FCR_REQ0) || (state_reg == FCR_REQ1));
    assign mem_req_addr      = (state_reg == FCR_REQ1) ? base_reg + ADDR_W'(BEAT_BYTES) : base_reg;
    assign accept            = pc_index_valid && pc_index_ready;

    // During the done pulse the freshly assembled line is presented directly;
    // otherwise the last reported line is held.
    assign fetch_line    = pc_operation_done ? line_buf : line_out_reg;
    assign fetch_line_pc = pc_operation_done ? base_reg : line_pc_reg;

    // Next-state logic; redirect overrides every other transition.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            FCR_IDLE: begin
                if (accept) state_next = FCR_REQ0;
            end
            FCR_REQ0, FCR_REQ1: begin
                if (redirect_valid)
                    state_next = mem_req_ready ? FCR_DRAIN : FCR_IDLE;
                else if (mem_req_ready)
                    state_next = (state_reg == FCR_REQ0) ? FCR_WAIT0 : FCR_WAIT1;
            end
            FCR_WAIT0, FCR_WAIT1: begin
                if (redirect_valid)
                    state_next = mem_resp_valid ? FCR_IDLE : FCR_DRAIN;
                else if (mem_resp_valid)
                    state_next = (state_reg == FCR_WAIT0) ? FCR_REQ1 : FCR_DONE;
            end
            FCR_DONE: state_next = FCR_IDLE;
            // A redirect here keeps draining; once the outstanding beat has
            // returned nothing is in flight, so leave regardless of redirect.
            FCR_DRAIN: begin
                if (mem_resp_valid) state_next = FCR_IDLE;
            end
            default: state_next = FCR_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_n) state_reg <= FCR_IDLE;
        else          state_reg <= state_next;
    end

    // Line base address latched at the request handshake.
    always_ff @(posedge clock) begin
        if (!reset_n)    base_reg <= '0;
        else if (accept) base_reg <= {pc_index[`PC_RANGE(ADDR_W)], {LINE_OFF_W{1'b0}}};
    end

    // One capture register per beat, loaded in that beat's wait state.
    for (genvar gi = 0; gi < 2; gi++) begin : g_beat
        localparam fcr_state_t CAP_STATE = (gi == 0) ? FCR_WAIT0 : FCR_WAIT1;
        logic [BEAT_W-1:0] beat_reg;

        // Capture beat gi unless the same cycle carries a redirect.
        always_ff @(posedge clock) begin
            if (!reset_n)
                beat_reg <= '0;
            else if ((state_reg == CAP_STATE) && mem_resp_valid && !redirect_valid)
                beat_reg <= mem_resp_data;
        end
    end

    assign line_buf = {g_beat[1].beat_reg, g_beat[0].beat_reg};

    // Reported line and address, committed only on an unsuppressed done.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            line_out_reg <= '0;
            line_pc_reg  <= '0;
        end else if (pc_operation_done) begin
            line_out_reg <= line_buf;
            line_pc_reg  <= base_reg;
        end
    end

`ifndef SYNTHESIS
    // A reset taken while a read was outstanding leaves one orphan response
    // that may legally arrive in any state afterwards.
    logic orphan_reg;
    always_ff @(posedge clock) begin
        if (!reset_n) orphan_reg <= orphan_reg || fcr_resp_expected(state_reg);
        else          orphan_reg <= orphan_reg && !mem_resp_valid;
    end

    a_resp_protocol: assert property (@(posedge clock) disable iff (!reset_n)
        mem_resp_valid |-> (fcr_resp_expected(state_reg) || orphan_reg))
        else $error("mem_resp_valid with no read outstanding");

    a_req_stable: assert property (@(posedge clock) disable iff (!reset_n)
        (mem_req_valid && !mem_req_ready && !redirect_valid)
            |=> (mem_req_valid && $stable(mem_req_addr)))
        else $error("memory request changed while stalled");
`endif

endmodule

// File: tb/tb_fetch_chan_resp.sv
// Directed bench for fetch_chan_resp: drives the PC and memory sides cycle
// by cycle and compares every output against hand-computed values.
module tb_fetch_chan_resp;

    localparam int ADDR_W = 64;
    localparam int BEAT_W = 64;

    logic                clock = 1'b0;
    logic                reset_n = 1'b0;
    logic                redirect_valid = 1'b0;
    logic                pc_index_valid = 1'b0;
    logic [ADDR_W-1:0]   pc_index = '0;
    logic                mem_req_ready = 1'b0;
    logic                mem_resp_valid = 1'b0;
    logic [BEAT_W-1:0]   mem_resp_data = '0;
    logic                pc_index_ready;
    logic                pc_operation_done;
    logic [2*BEAT_W-1:0] fetch_line;
    logic [ADDR_W-1:0]   fetch_line_pc;
    logic                mem_req_valid;
    logic [ADDR_W-1:0]   mem_req_addr;

    fetch_chan_resp #(.ADDR_W(ADDR_W), .BEAT_W(BEAT_W)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .redirect_valid    (redirect_valid),
        .pc_index_valid    (pc_index_valid),
        .pc_index          (pc_index),
        .pc_index_ready    (pc_index_ready),
        .pc_operation_done (pc_operation_done),
        .fetch_line        (fetch_line),
        .fetch_line_pc     (fetch_line_pc),
        .mem_req_valid     (mem_req_valid),
        .mem_req_addr      (mem_req_addr),
        .mem_req_ready     (mem_req_ready),
        .mem_resp_valid    (mem_resp_valid),
        .mem_resp_data     (mem_resp_data)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int req_cnt = 0;
    int done_cnt = 0;
    logic [2*BEAT_W-1:0] exp_line = '0;
    logic [ADDR_W-1:0]   exp_pc = '0;

    // Count request handshakes and done pulses mid-cycle.
    always @(negedge clock) begin
        if (mem_req_valid && mem_req_ready) req_cnt++;
        if (pc_operation_done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One full fetch; stall = cycles of mem_req_ready low in REQ0,
    // lat = cycles from request accept to response, redir_done = redirect in DONE.
    task automatic run_fetch(input logic [63:0] pc, input logic [63:0] d0, input logic [63:0] d1,
                             input int stall, input int lat, input bit redir_done);
        logic [63:0] base;
        logic [63:0] a;
        int r0;
        int dn;
        base = {pc[63:4], 4'h0};
        r0 = req_cnt;
        dn = done_cnt;
        pc_index = pc;
        pc_index_valid = 1'b1;
        #1 chk("accept_ready", pc_index_ready, 1);
        tick();
        pc_index_valid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            a = base + 64'(8 * b);
            for (int s = 0; s < ((b == 0) ? stall : 0); s++) begin
                mem_req_ready = 1'b0;
                #1 chk("stall_valid", mem_req_valid, 1);
                chk("stall_addr", mem_req_addr, a);
                tick();
            end
            mem_req_ready = 1'b1;
            #1 chk("req_valid", mem_req_valid, 1);
            chk("req_addr", mem_req_addr, a);
            tick();
            mem_req_ready = 1'b0;
            for (int l = 1; l < lat; l++) begin
                #1 chk("wait_no_req", mem_req_valid, 0);
                tick();
            end
            mem_resp_valid = 1'b1;
            mem_resp_data = (b == 0) ? d0 : d1;
            #1 chk("no_early_done", pc_operation_done, 0);
            tick();
            mem_resp_valid = 1'b0;
        end
        redirect_valid = redir_done;
        #1;
        if (!redir_done) begin
            exp_line = {d1, d0};
            exp_pc = base;
        end
        chk("done_pulse", pc_operation_done, !redir_done);
        chk("done_line", fetch_line, exp_line);
        chk("done_line_pc", fetch_line_pc, exp_pc);
        tick();
        redirect_valid = 1'b0;
        #1 chk("done_once", pc_operation_done, 0);
        chk("back_idle", pc_index_ready, 1);
        chk("line_held", fetch_line, exp_line);
        chk("line_pc_held", fetch_line_pc, exp_pc);
        chk("req_count", req_cnt - r0, 2);
        chk("done_count", done_cnt - dn, redir_done ? 0 : 1);
        $display("txn fetch pc=%h stall=%0d lat=%0d redir_done=%0d line=%h line_pc=%h",
                 pc, stall, lat, redir_done, fetch_line, fetch_line_pc);
    endtask

    initial begin
        int r0;
        int dn;

        // Reset state.
        tick();
        tick();
        chk("rst_ready", pc_index_ready, 0);
        chk("rst_done", pc_operation_done, 0);
        chk("rst_req_valid", mem_req_valid, 0);
        chk("rst_line", fetch_line, 0);
        chk("rst_line_pc", fetch_line_pc, 0);
        reset_n = 1'b1;
        tick();
        chk("post_rst_ready", pc_index_ready, 1);
        $display("txn reset released");

        // Basic fetch, done at N+5.
        run_fetch(64'h8000_0004, 64'h1111, 64'h2222, 0, 1, 1'b0);

        // Memory stall in REQ0 and 4-cycle response latency.
        run_fetch(64'h8000_0048, 64'hAAAA_0000_0000_0001, 64'hBBBB_0000_0000_0002, 3, 4, 1'b0);

        // Redirect while waiting for beat 0.
        r0 = req_cnt;
        dn = done_cnt;
        pc_index = 64'h8000_1000;
        pc_index_valid = 1'b1;
        #1 tick();
        pc_index_valid = 1'b0;
        mem_req_ready = 1'b1;
        #1 tick();
        mem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        #1 chk("redir_wait_ready", pc_index_ready, 0);
        tick();
        redirect_valid = 1'b0;
        #1 chk("drain_ready", pc_index_ready, 0);
        chk("drain_req", mem_req_valid, 0);
        tick();
        mem_resp_valid = 1'b1;
        mem_resp_data = 64'hDEAD_BEEF;
        #1 chk("drain_resp_ready", pc_index_ready, 0);
        chk("drain_resp_done", pc_operation_done, 0);
        tick();
        mem_resp_valid = 1'b0;
        #1 chk("ready_after_drop", pc_index_ready, 1);
        chk("drain_no_done", pc_operation_done, 0);
        chk("drain_line_kept", fetch_line, exp_line);
        chk("drain_req_count", req_cnt - r0, 1);
        chk("drain_done_count", done_cnt - dn, 0);
        $display("txn redirect in WAIT0 pc=8000_1000 drained");
        run_fetch(64'h9000_0000, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 0, 1, 1'b0);

        // Redirect coincident with DONE: nothing reported, previous line kept.
        run_fetch(64'hA000_0010, 64'h3333, 64'h4444, 0, 2, 1'b1);

        // Redirect coincident with a request in IDLE.
        r0 = req_cnt;
        pc_index = 64'hD000_0000;
        pc_index_valid = 1'b1;
        redirect_valid = 1'b1;
        #1 chk("redir_hs_ready", pc_index_ready, 0);
        tick();
        pc_index_valid = 1'b0;
        redirect_valid = 1'b0;
        #1 chk("redir_hs_no_req", mem_req_valid, 0);
        chk("redir_hs_idle", pc_index_ready, 1);
        tick();
        #1 chk("redir_hs_no_req2", mem_req_valid, 0);
        chk("redir_hs_req_count", req_cnt - r0, 0);
        $display("txn redirect with handshake refused");

        // Reset in WAIT1 followed by a late response.
        dn = done_cnt;
        pc_index = 64'hB000_0020;
        pc_index_valid = 1'b1;
        #1 tick();
        pc_index_valid = 1'b0;
        mem_req_ready = 1'b1;
        #1 tick();
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data = 64'h5555;
        #1 tick();
        mem_resp_valid = 1'b0;
        mem_req_ready = 1'b1;
        #1 tick();
        mem_req_ready = 1'b0;
        reset_n = 1'b0;
        #1 chk("midrst_ready", pc_index_ready, 0);
        chk("midrst_req", mem_req_valid, 0);
        chk("midrst_done", pc_operation_done, 0);
        tick();
        reset_n = 1'b1;
        mem_resp_valid = 1'b1;
        mem_resp_data = 64'h6666;
        exp_line = '0;
        exp_pc = '0;
        #1 chk("late_line", fetch_line, exp_line);
        chk("late_line_pc", fetch_line_pc, exp_pc);
        chk("late_done", pc_operation_done, 0);
        chk("late_req", mem_req_valid, 0);
        chk("late_ready", pc_index_ready, 1);
        tick();
        mem_resp_valid = 1'b0;
        #1 chk("late_ignored_idle", pc_index_ready, 1);
        chk("late_ignored_done", pc_operation_done, 0);
        chk("late_ignored_req", mem_req_valid, 0);
        chk("midrst_done_count", done_cnt - dn, 0);
        $display("txn reset in WAIT1, late response ignored");

        // Recovery after the mid-operation reset.
        run_fetch(64'hC000_0008, 64'h7777, 64'h8888, 1, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/fetch_chan_resp.md
Name: fetch_chan_resp

Overview:
- Responder end of the frontend fetch-request channel. Accepts PC index requests from the PC controller over a valid/ready handshake.
- Fetches one 16-byte aligned instruction line as two 64-bit beats from the memory/DDR channel, then returns the line with a one-cycle operation-done pulse.
- Sits between the PC controller and the memory arbiter. On redirect it discards in-flight work so no stale line is ever reported.

Parameters:
- ADDR_W, 64, request/memory address width.
- BEAT_W, 64, memory data beat width. Line width is 2*BEAT_W.

Ports:
- clock  in  1  clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset; sampled on rising edge of clock.
- redirect_valid  in  1  frontend redirect/flush.
- pc_index_valid  in  1  fetch request valid.
- pc_index  in  ADDR_W  fetch PC; only bits [ADDR_W-1:4] are used.
- pc_index_ready  out  1  request accepted this cycle.
- pc_operation_done  out  1  one-cycle pulse; fetch_line is valid.
- fetch_line  out  2*BEAT_W  {beat1, beat0}; beat0 is at the lower address.
- fetch_line_pc  out  ADDR_W  aligned line address of fetch_line.
- mem_req_valid  out  1  memory read request.
- mem_req_addr  out  ADDR_W  8-byte aligned beat address.
- mem_req_ready  in  1  memory accepts request.
- mem_resp_valid  in  1  read data valid; always accepted, no backpressure.
- mem_resp_data  in  BEAT_W  read data.

Behaviour:
- Reset values: state=IDLE, pc_index_ready=0, pc_operation_done=0, mem_req_valid=0, fetch_line=0, fetch_line_pc=0, base=0.
- A reset in any state returns to IDLE next cycle. A mem_resp_valid arriving later is ignored.
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE, DRAIN.
- pc_index_ready = (state==IDLE) & ~redirect_valid. This is combinational.
  - The PC reported in a redirect cycle is stale, so the handshake is refused in that cycle.
- IDLE: on pc_index_valid & pc_index_ready, latch base={pc_index[ADDR_W-1:4],4'b0} and go to REQ0.
- REQ0: mem_req_valid=1, mem_req_addr=base. On mem_req_ready, go to WAIT0.
- WAIT0: on mem_resp_valid, capture fetch_line[BEAT_W-1:0] and go to REQ1.
- REQ1: mem_req_valid=1, mem_req_addr=base+8. On mem_req_ready, go to WAIT1.
- WAIT1: on mem_resp_valid, capture the upper beat and go to DONE.
- DONE: pc_operation_done=1 for exactly one cycle. fetch_line_pc=base, registered and held until the next DONE. Go to IDLE.
- Latency with mem_req_ready=1 and 1-cycle read latency:
  - handshake at cycle N;
  - REQ0 N+1, WAIT0 N+2, REQ1 N+3, WAIT1 N+4;
  - done pulse at N+5.
- mem_req_valid and mem_req_addr stay stable while stalled in REQx. A request is never dropped without a redirect.
- At most one memory request is outstanding.
- Redirect handling (redirect has priority over all other transitions):
  - IDLE: no action; request refused this cycle.
  - REQx with mem_req_ready=0: go to IDLE; no memory traffic issued.
  - REQx with mem_req_ready=1 in the same cycle: the request is issued, so go to DRAIN.
  - WAITx with mem_resp_valid=0: go to DRAIN.
  - WAITx with mem_resp_valid=1 in the same cycle: data is discarded; go to IDLE.
  - DONE: suppress pc_operation_done; go to IDLE; fetch_line and fetch_line_pc are not updated.
- DRAIN: pc_index_ready=0, mem_req_valid=0. On mem_resp_valid, discard the data and go to IDLE.
  - A further redirect in DRAIN stays in DRAIN.
- Address arithmetic is modulo 2^ADDR_W. base+8 never carries into bit 4 because base[3:0]=0.
- mem_resp_valid in IDLE, REQx or DONE is a protocol error. It is ignored, and simulation-only assertions flag it.

Decomposition:
- Shared frontend package holds:
  - state encoding enum (FCR_IDLE..FCR_DRAIN, 3 bits);
  - LINE_BYTES=16 and BEAT_BYTES=8 constants;
  - PC_RANGE width macro.
- No sub-module is needed. A single FSM with a datapath register file of base, line and line_pc.

Test Plan:
- Basic fetch:
  - stimulus: pc_index=0x8000_0004, mem ready=1, resp beats 0x1111 then 0x2222;
  - response: mem addrs 0x8000_0000 then 0x8000_0008; done at N+5; fetch_line={0x2222,0x1111}; fetch_line_pc=0x8000_0000.
- Memory stall:
  - stimulus: mem_req_ready low for 3 cycles in REQ0, resp latency 4;
  - response: mem_req_valid/addr held stable; exactly two requests; single done pulse.
- Redirect while waiting:
  - stimulus: redirect in WAIT0, resp arrives 2 cycles later;
  - response: enters DRAIN, resp discarded, no done; ready reasserted the cycle after the drop; next request pc=0x9000_0000 fetched correctly.
- Redirect in DONE:
  - stimulus: redirect coincident with DONE;
  - response: pc_operation_done=0; fetch_line_pc unchanged; FSM back in IDLE.
- Redirect with handshake:
  - stimulus: pc_index_valid=1 and redirect_valid=1 in IDLE;
  - response: pc_index_ready=0 that cycle; no memory request issued.
- Reset mid-operation:
  - stimulus: reset_n=0 for 1 cycle in WAIT1, then a late resp;
  - response: all outputs at reset values; late resp ignored; no done pulse.
